// File: rtl/fft_seq_ctrl.sv
// rtl/fft_seq_ctrl.sv - address/enable sequencer for an in-place radix-2 DIF FFT/IFFT engine
// Load in natural order, iterate stages with delayed write-back, unload in bit-reversed order.
module fft_seq_ctrl #(
  parameter int LOG2N    = 10,
  parameter int BFLY_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_fft,
  input  logic                       start_ifft,
  input  logic                       abort,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LOG2N-1:0]           rd_addr_a,
  output logic [LOG2N-1:0]           rd_addr_b,
  output logic [LOG2N-1:0]           wr_addr_a,
  output logic [LOG2N-1:0]           wr_addr_b,
  output logic                       wr_en_bfly,
  output logic                       wr_en_load,
  output logic [LOG2N-2:0]           twiddle_idx,
  output logic                       twiddle_conj,
  output logic [$clog2(LOG2N)-1:0]   stage,
  output logic                       busy,
  output logic                       done
);

  localparam int SW = $clog2(LOG2N);
  localparam int CW = LOG2N - 1;
  localparam int LW = (BFLY_LAT > 0) ? BFLY_LAT - 1 : 0;

  localparam logic [LOG2N-1:0] A_ONE      = LOG2N'(1);
  localparam logic [LOG2N-1:0] LAST_ADDR  = {LOG2N{1'b1}};
  localparam logic [CW-1:0]    C_ONE      = CW'(1);
  localparam logic [CW-1:0]    LAST_BFLY  = {CW{1'b1}};
  localparam logic [SW-1:0]    S_ONE      = SW'(1);
  localparam logic [SW-1:0]    LAST_STAGE = SW'(LOG2N - 1);
  localparam logic [2:0]       LAST_WAIT  = 3'(LW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_WAIT,
    S_UNLOAD
  } state_t;

  state_t state, state_next;

  logic             mode;
  logic [LOG2N-1:0] load_cnt;
  logic [CW-1:0]    bfly_cnt;
  logic [LOG2N-1:0] unload_cnt;
  logic [2:0]       wait_cnt;
  logic [SW-1:0]    stage_q;
  logic             stage_end;
  logic             job_end;

  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] c_ext;
  logic [LOG2N-1:0] pos;
  logic [LOG2N-1:0] bfly_a;
  logic [LOG2N-1:0] bfly_b;
  logic [CW-1:0]    bfly_tw;
  logic [LOG2N-1:0] rev;
  logic             issue;

  logic             wb_valid;
  logic [LOG2N-1:0] wb_a;
  logic [LOG2N-1:0] wb_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    stage_end  = 1'b0;
    job_end    = 1'b0;
    case (state)
      S_IDLE:    if (start_fft || start_ifft) state_next = S_LOAD;
      S_LOAD:    if (in_valid && load_cnt == LAST_ADDR) state_next = S_COMPUTE;
      S_COMPUTE: begin
        if (bfly_cnt == LAST_BFLY) begin
          if (BFLY_LAT == 0) stage_end = 1'b1;
          else               state_next = S_WAIT;
        end
      end
      S_WAIT:    if (wait_cnt == LAST_WAIT) stage_end = 1'b1;
      S_UNLOAD:  if (out_ready && unload_cnt == LAST_ADDR) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
    if (stage_end) begin
      if (stage_q == LAST_STAGE) begin
        job_end    = 1'b1;
        state_next = S_UNLOAD;
      end else begin
        state_next = S_COMPUTE;
      end
    end
    if (abort) begin
      state_next = S_IDLE;
      stage_end  = 1'b0;
      job_end    = 1'b0;
    end
  end

  // Counters return to zero by wrapping exactly at their state's exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode       <= 1'b0;
      load_cnt   <= '0;
      bfly_cnt   <= '0;
      unload_cnt <= '0;
      wait_cnt   <= '0;
      stage_q    <= '0;
    end else if (abort) begin
      mode       <= 1'b0;
      load_cnt   <= '0;
      bfly_cnt   <= '0;
      unload_cnt <= '0;
      wait_cnt   <= '0;
      stage_q    <= '0;
    end else begin
      if (state == S_IDLE && (start_fft || start_ifft)) mode <= ~start_fft;
      if (state == S_LOAD && in_valid) load_cnt <= load_cnt + A_ONE;
      if (state == S_COMPUTE) bfly_cnt <= bfly_cnt + C_ONE;
      if (state == S_UNLOAD && out_ready) unload_cnt <= unload_cnt + A_ONE;
      wait_cnt <= (state == S_WAIT && !stage_end) ? wait_cnt + 3'd1 : 3'd0;
      if (job_end)        stage_q <= '0;
      else if (stage_end) stage_q <= stage_q + S_ONE;
    end
  end

  // Butterfly pair: insert a zero bit at the span position of the cycle index.
  always_comb begin
    span    = A_ONE << (LAST_STAGE - stage_q);
    c_ext   = {1'b0, bfly_cnt};
    pos     = c_ext & (span - A_ONE);
    bfly_a  = ((c_ext & ~(span - A_ONE)) << 1) | pos;
    bfly_b  = bfly_a | span;
    bfly_tw = pos[CW-1:0] << stage_q;
    rev     = '0;
    for (int i = 0; i < LOG2N; i++) begin
      rev[i] = unload_cnt[LOG2N-1-i];
    end
  end

  assign issue = (state == S_COMPUTE);

  generate
    if (BFLY_LAT == 0) begin : g_direct
      assign wb_valid = issue;
      assign wb_a     = bfly_a;
      assign wb_b     = bfly_b;
    end else begin : g_pipe
      logic [BFLY_LAT-1:0] vld;
      logic [LOG2N-1:0]    pa [BFLY_LAT];
      logic [LOG2N-1:0]    pb [BFLY_LAT];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld <= '0;
          for (int i = 0; i < BFLY_LAT; i++) begin
            pa[i] <= '0;
            pb[i] <= '0;
          end
        end else if (abort) begin
          vld <= '0;
          for (int i = 0; i < BFLY_LAT; i++) begin
            pa[i] <= '0;
            pb[i] <= '0;
          end
        end else begin
          for (int i = BFLY_LAT - 1; i > 0; i--) begin
            vld[i] <= vld[i-1];
            pa[i]  <= pa[i-1];
            pb[i]  <= pb[i-1];
          end
          vld[0] <= issue;
          pa[0]  <= bfly_a;
          pb[0]  <= bfly_b;
        end
      end

      assign wb_valid = vld[BFLY_LAT-1];
      assign wb_a     = pa[BFLY_LAT-1];
      assign wb_b     = pb[BFLY_LAT-1];
    end
  endgenerate

  always_comb begin
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    wr_en_load   = 1'b0;
    rd_addr_a    = '0;
    rd_addr_b    = '0;
    twiddle_idx  = '0;
    busy         = (state != S_IDLE);
    twiddle_conj = mode & busy;
    stage        = stage_q;
    done         = job_end;
    wr_en_bfly   = wb_valid;
    wr_addr_a    = wb_valid ? wb_a : '0;
    wr_addr_b    = wb_valid ? wb_b : '0;
    case (state)
      S_LOAD: begin
        in_ready   = 1'b1;
        wr_en_load = in_valid;
        wr_addr_a  = load_cnt;
      end
      S_COMPUTE: begin
        rd_addr_a   = bfly_a;
        rd_addr_b   = bfly_b;
        twiddle_idx = bfly_tw;
      end
      S_UNLOAD: begin
        out_valid = 1'b1;
        rd_addr_a = rev;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb/tb_fft_seq_ctrl.sv - directed bench for fft_seq_ctrl at N=8/lat 2 and N=4/lat 0
module tb_fft_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic abort;
  logic in_valid;
  logic out_ready;
  logic start_fft8, start_ifft8, start_fft4, start_ifft4;

  logic       in_ready8, out_valid8, wr_en_bfly8, wr_en_load8, twiddle_conj8, busy8, done8;
  logic [2:0] rd_addr_a8, rd_addr_b8, wr_addr_a8, wr_addr_b8;
  logic [1:0] twiddle_idx8, stage8;

  logic       in_ready4, out_valid4, wr_en_bfly4, wr_en_load4, twiddle_conj4, busy4, done4;
  logic [1:0] rd_addr_a4, rd_addr_b4, wr_addr_a4, wr_addr_b4;
  logic [0:0] twiddle_idx4, stage4;

  int checks = 0;
  int failures = 0;

  int tab8_a [12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
  int tab8_b [12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
  int tab8_t [12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};
  int rev8   [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
  int tab4_a [4]  = '{0, 1, 0, 2};
  int tab4_b [4]  = '{2, 3, 1, 3};
  int tab4_t [4]  = '{0, 1, 0, 0};
  int rev4   [4]  = '{0, 2, 1, 3};

  always #5 clk = ~clk;

  fft_seq_ctrl #(.LOG2N(3), .BFLY_LAT(2)) u_dut8 (
    .clk(clk), .rst(rst), .start_fft(start_fft8), .start_ifft(start_ifft8), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready8), .out_valid(out_valid8), .out_ready(out_ready),
    .rd_addr_a(rd_addr_a8), .rd_addr_b(rd_addr_b8), .wr_addr_a(wr_addr_a8), .wr_addr_b(wr_addr_b8),
    .wr_en_bfly(wr_en_bfly8), .wr_en_load(wr_en_load8), .twiddle_idx(twiddle_idx8),
    .twiddle_conj(twiddle_conj8), .stage(stage8), .busy(busy8), .done(done8)
  );

  fft_seq_ctrl #(.LOG2N(2), .BFLY_LAT(0)) u_dut4 (
    .clk(clk), .rst(rst), .start_fft(start_fft4), .start_ifft(start_ifft4), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready4), .out_valid(out_valid4), .out_ready(out_ready),
    .rd_addr_a(rd_addr_a4), .rd_addr_b(rd_addr_b4), .wr_addr_a(wr_addr_a4), .wr_addr_b(wr_addr_b4),
    .wr_en_bfly(wr_en_bfly4), .wr_en_load(wr_en_load4), .twiddle_idx(twiddle_idx4),
    .twiddle_conj(twiddle_conj4), .stage(stage4), .busy(busy4), .done(done4)
  );

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet8(input string tag);
    check({tag, "_busy"}, busy8, 0);
    check({tag, "_in_ready"}, in_ready8, 0);
    check({tag, "_out_valid"}, out_valid8, 0);
    check({tag, "_wr_en"}, {wr_en_bfly8, wr_en_load8}, 0);
    check({tag, "_addr"}, {rd_addr_a8, rd_addr_b8, wr_addr_a8, wr_addr_b8}, 0);
    check({tag, "_tw"}, {twiddle_idx8, twiddle_conj8, stage8, done8}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s, j, wt, n_wr, n_done, n_ready;
    bit exp_wr;
    rst = 1'b1; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    start_fft8 = 1'b0; start_ifft8 = 1'b0; start_fft4 = 1'b0; start_ifft4 = 1'b0;
    step(); step();
    #1;
    check_quiet8("reset");
    check("reset_busy4", {busy4, in_ready4, out_valid4, wr_en_bfly4}, 0);
    rst = 1'b0;

    // forward transform, N=8, latency 2
    step(); start_fft8 = 1'b1;
    step(); start_fft8 = 1'b0; in_valid = 1'b1;
    n_ready = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (in_ready8) n_ready++;
      check("load_wr_en", wr_en_load8, 1);
      check("load_addr", wr_addr_a8, i);
      step();
    end
    in_valid = 1'b0;
    #1;
    check("load_ready_cycles", n_ready + in_ready8, 8);
    for (int t = 1; t <= 18; t++) begin
      s = (t - 1) / 6;
      j = (t - 1) % 6;
      check("cmp_stage", stage8, s);
      check("cmp_conj", twiddle_conj8, 0);
      if (j < 4) begin
        check("cmp_rd_a", rd_addr_a8, tab8_a[s*4+j]);
        check("cmp_rd_b", rd_addr_b8, tab8_b[s*4+j]);
        check("cmp_tw", twiddle_idx8, tab8_t[s*4+j]);
      end
      wt = t - 3;
      exp_wr = (wt >= 0) && ((wt % 6) < 4);
      check("wb_en", wr_en_bfly8, exp_wr);
      if (exp_wr) begin
        check("wb_addr_a", wr_addr_a8, tab8_a[(wt/6)*4 + wt%6]);
        check("wb_addr_b", wr_addr_b8, tab8_b[(wt/6)*4 + wt%6]);
      end
      check("done_timing", done8, (t == 18));
      step();
    end
    for (int u = 0; u < 15; u++) begin
      out_ready = (u % 2 == 0);
      #1;
      check("unl_valid", out_valid8, 1);
      check("unl_addr", rd_addr_a8, rev8[(u+1)/2]);
      step();
    end
    out_ready = 1'b0;
    #1;
    check("unl_idle_busy", busy8, 0);
    check("unl_idle_valid", out_valid8, 0);

    // inverse transform, aborted during stage 1
    step(); start_ifft8 = 1'b1;
    step(); start_ifft8 = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("ifft_load_conj", twiddle_conj8, 1);
      step();
    end
    in_valid = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      #1;
      check("ifft_cmp_conj", twiddle_conj8, 1);
      if (t == 8) begin
        check("abort_stage", stage8, 1);
        abort = 1'b1;
      end
      step();
    end
    abort = 1'b0;
    #1;
    check("abort_busy", busy8, 0);
    check("abort_wr", wr_en_bfly8, 0);
    n_wr = 0; n_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (wr_en_bfly8) n_wr++;
      if (done8) n_done++;
      step();
    end
    check("abort_no_wr", n_wr, 0);
    check("abort_no_done", n_done, 0);

    // abort beats start in IDLE
    start_fft8 = 1'b1; abort = 1'b1;
    step(); start_fft8 = 1'b0; abort = 1'b0;
    #1;
    check("abort_over_start", busy8, 0);

    // simultaneous starts pick FFT; reset mid-load
    start_fft8 = 1'b1; start_ifft8 = 1'b1;
    step(); start_fft8 = 1'b0; start_ifft8 = 1'b0;
    #1;
    check("both_busy", busy8, 1);
    check("both_conj", twiddle_conj8, 0);
    in_valid = 1'b1;
    step(); step(); step();
    #1;
    check("midload_addr", wr_addr_a8, 3);
    rst = 1'b1;
    #1;
    check_quiet8("async_rst");
    step(); rst = 1'b0; in_valid = 1'b0;

    // N=4, latency 0
    step(); start_fft4 = 1'b1;
    step(); start_fft4 = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("l0_load_en", wr_en_load4, 1);
      check("l0_load_addr", wr_addr_a4, i);
      step();
    end
    in_valid = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      #1;
      check("l0_rd_a", rd_addr_a4, tab4_a[t-1]);
      check("l0_rd_b", rd_addr_b4, tab4_b[t-1]);
      check("l0_tw", twiddle_idx4, tab4_t[t-1]);
      check("l0_wr_en", wr_en_bfly4, 1);
      check("l0_wr_a", wr_addr_a4, tab4_a[t-1]);
      check("l0_wr_b", wr_addr_b4, tab4_b[t-1]);
      check("l0_done", done4, (t == 4));
      step();
    end
    out_ready = 1'b1;
    for (int u = 0; u < 4; u++) begin
      #1;
      check("l0_unl_addr", rd_addr_a4, rev4[u]);
      step();
    end
    out_ready = 1'b0;
    #1;
    check("l0_idle", busy4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_seq_ctrl.md
Name: fft_seq_ctrl

Overview:
- Parametrised sequencer for the in-place radix-2 decimation-in-frequency FFT/IFFT engine.
- Owns four phases: sample load, stage/cycle iteration, butterfly write-back timing, and natural-order unload.
- Drives the dual-port sample RAM addresses and write enables, the twiddle ROM index and the conjugate flag. It does not touch the datapath itself.
- Generalises the fixed 1024-point control:
  - point count is set by parameter;
  - butterfly pipeline latency is configurable, with RAW-safe stage stalls;
  - load and unload use valid/ready handshakes;
  - unload is bit-reverse reordered;
  - a synchronous abort is provided.

Parameters:
LOG2N, 10, log2 of point count N (N = 2**LOG2N); legal range 2..12.
BFLY_LAT, 2, cycles from read address issue to butterfly result valid at the RAM write port; legal range 0..7.

Ports:
clk  input  1  clock.
rst  input  1  asynchronous active-high reset.
start_fft  input  1  single-cycle pulse; starts a forward transform from IDLE.
start_ifft  input  1  single-cycle pulse; starts an inverse transform from IDLE.
abort  input  1  synchronous; returns to IDLE on the next edge.
in_valid  input  1  load sample present.
in_ready  output  1  sequencer accepts a load sample.
out_valid  output  1  unload sample present at the RAM A read port.
out_ready  input  1  consumer takes the unload sample.
rd_addr_a  output  LOG2N  RAM read address A; used by butterfly A and by unload.
rd_addr_b  output  LOG2N  RAM read address B.
wr_addr_a  output  LOG2N  RAM write address A; used by butterfly A and by load.
wr_addr_b  output  LOG2N  RAM write address B.
wr_en_bfly  output  1  write butterfly results to A and B.
wr_en_load  output  1  write the external sample to wr_addr_a.
twiddle_idx  output  LOG2N-1  twiddle ROM index.
twiddle_conj  output  1  conjugate twiddle; 1 for IFFT.
stage  output  $clog2(LOG2N)  current stage number.
busy  output  1  high in any state other than IDLE.
done  output  1  one-cycle pulse at the end of the last write-back.

Behaviour:
- Reset: state IDLE. Every output is 0, including in_ready, out_valid, both write enables, all addresses, twiddle_idx, twiddle_conj and stage. Reset mid-operation discards all progress.
- RAM read is combinational. The write port is synchronous.
- IDLE:
  - start_fft -> LOAD with mode=FFT.
  - start_ifft -> LOAD with mode=IFFT.
  - If both are asserted, FFT wins.
  - Starts outside IDLE are ignored.
  - Mode is latched at start; twiddle_conj = mode for the whole job.
- LOAD:
  - in_ready=1.
  - A transfer occurs when in_valid & in_ready: wr_en_load=1 and wr_addr_a = load counter (0..N-1, natural order).
  - After the transfer at address N-1 -> COMPUTE with stage 0, cycle 0.
- COMPUTE: one butterfly issued per cycle, with c = 0..N/2-1.
  - span = N >> (stage+1).
  - pos = c mod span.
  - rd_addr_a = (c / span)*2*span + pos.
  - rd_addr_b = rd_addr_a + span.
  - twiddle_idx = pos << stage.
  - After c = N/2-1 -> WAIT.
- Write-back:
  - The issued rd_addr_a/b are delayed by a BFLY_LAT-deep shift register, with a valid bit, onto wr_addr_a/b and wr_en_bfly.
  - With BFLY_LAT=0, the write occurs in the same cycle to the read addresses.
- WAIT:
  - No issue. Hold for BFLY_LAT cycles so the last write of the stage lands before the next stage reads.
  - With BFLY_LAT=0, WAIT is skipped.
  - Then: stage+1 -> COMPUTE, or, if stage = LOG2N-1, done=1 for 1 cycle -> UNLOAD.
- Compute duration: exactly LOG2N*(N/2 + BFLY_LAT) cycles from the first issue to the done pulse inclusive.
- UNLOAD:
  - out_valid=1.
  - rd_addr_a = bitrev(k), where k is the unload counter 0..N-1.
  - k advances on out_valid & out_ready.
  - After k=N-1 is accepted -> IDLE.
  - Data must stay stable while out_ready=0.
- abort (any state): the next state is IDLE.
  - Pending write-back shift-register contents are flushed: no further wr_en_bfly.
  - No done pulse.
  - abort has priority over start in the same cycle.
- Counters wrap only through state exit. They never free-run.

Test Plan:
- N=8, BFLY_LAT=2, start_fft, 8 samples with in_valid always 1 -> in_ready high exactly 8 cycles; wr_addr_a 0..7 with wr_en_load; then COMPUTE.
- Same run, stage 0 -> (rd_a, rd_b, tw) = (0,4,0),(1,5,1),(2,6,2),(3,7,3).
  - Stage 1 -> (0,2,0),(1,3,2),(4,6,0),(5,7,2).
  - Stage 2 -> (0,1,0),(2,3,0),(4,5,0),(6,7,0).
  - wr_addr matches rd_addr delayed 2 cycles.
  - done pulses 18 cycles after the first issue.
- start_ifft with N=8 -> twiddle_conj=1 throughout.
  - start_fft and start_ifft in the same cycle -> twiddle_conj=0.
- UNLOAD with out_ready toggling 1,0,1,... -> rd_addr_a sequence 0,4,2,6,1,5,3,7.
  - Each address is held while out_ready=0.
  - IDLE follows the 8th accept.
- abort during stage 1 -> IDLE next edge, busy=0, no further wr_en_bfly, no done.
  - rst asserted mid-LOAD -> all outputs 0 immediately (asynchronous).
- BFLY_LAT=0, N=4 -> done 4 cycles after the first issue; wr_addr equals rd_addr in each issue cycle.
